// File: rtl/morph_pkg.sv
// ============================================================================
// morph_pkg
// Shared defaults, state encoding and sizing helper for the morphology
// line-buffer front end.
// Revision: 1.0
// ============================================================================
`default_nettype none

package morph_pkg;

    localparam int PIC_WIDTH_DEF  = 250;
    localparam int PIC_HEIGHT_DEF = 250;
    localparam int WIDTH_DEF      = 24;

    localparam int COL_W = $clog2(PIC_WIDTH_DEF);
    localparam int ROW_W = $clog2(PIC_HEIGHT_DEF);

    typedef enum logic [0:0] {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_buffer_ram.sv
// ============================================================================
// line_buffer_ram
// One-line pixel store, single clock, shared read/write address.
// Revision: 1.0
// ============================================================================
`default_nettype none

module line_buffer_ram
    import morph_pkg::*;
#(
    parameter int DEPTH = PIC_WIDTH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    // Asynchronous read sees the pre-edge contents, so a same-address write
    // in this cycle returns the old pixel.
    assign rd_data = mem[addr];

endmodule

`default_nettype wire

// File: rtl/matrix_3row_gen.sv
// ============================================================================
// matrix_3row_gen
// Emits three vertically aligned pixels (rows n-2, n-1, n) per accepted pixel.
// Revision: 1.0
// ============================================================================
`default_nettype none

module matrix_3row_gen
    import morph_pkg::*;
#(
    parameter int PIC_WIDTH  = PIC_WIDTH_DEF,
    parameter int PIC_HEIGHT = PIC_HEIGHT_DEF,
    parameter int WIDTH      = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             frame_done
);

    localparam int COL_BITS = cnt_w(PIC_WIDTH);
    localparam int ROW_BITS = cnt_w(PIC_HEIGHT);

    localparam logic [COL_BITS-1:0] COL_LAST   = COL_BITS'(PIC_WIDTH - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST   = ROW_BITS'(PIC_HEIGHT - 1);
    localparam logic [ROW_BITS-1:0] ROW_PRIMED = ROW_BITS'(1);

    logic [COL_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    state_e              state_q, state_d;
    logic                valid_out_q, valid_out_d;
    logic                frame_done_q, frame_done_d;
    logic [WIDTH-1:0]    dout1_q, dout1_d;
    logic [WIDTH-1:0]    dout2_q, dout2_d;
    logic [WIDTH-1:0]    dout3_q, dout3_d;

    logic [WIDTH-1:0]    lb1_rd;
    logic [WIDTH-1:0]    lb2_rd;
    logic                col_last;
    logic                row_last;

    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);

    // lb1 holds the previous row; lb2 takes whatever lb1 is about to lose.
    line_buffer_ram #(
        .DEPTH (PIC_WIDTH),
        .WIDTH (WIDTH),
        .AW    (COL_BITS)
    ) u_lb1 (
        .clk     (clk),
        .wr_en   (valid_in),
        .addr    (col_q),
        .wr_data (din),
        .rd_data (lb1_rd)
    );

    line_buffer_ram #(
        .DEPTH (PIC_WIDTH),
        .WIDTH (WIDTH),
        .AW    (COL_BITS)
    ) u_lb2 (
        .clk     (clk),
        .wr_en   (valid_in),
        .addr    (col_q),
        .wr_data (lb1_rd),
        .rd_data (lb2_rd)
    );

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        state_d      = state_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        dout1_d      = dout1_q;
        dout2_d      = dout2_q;
        dout3_d      = dout3_q;

        if (valid_in) begin
            dout3_d     = din;
            dout2_d     = lb1_rd;
            dout1_d     = lb2_rd;
            valid_out_d = (state_q == RUN);

            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_BITS'(1);
            end else begin
                col_d = col_q + COL_BITS'(1);
            end

            case (state_q)
                PRIME: begin
                    if (col_last && (row_q == ROW_PRIMED)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (col_last && row_last) begin
                        state_d      = PRIME;
                        frame_done_d = 1'b1;
                    end
                end
                default: state_d = PRIME;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            state_q      <= PRIME;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            dout1_q      <= '0;
            dout2_q      <= '0;
            dout3_q      <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            state_q      <= state_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
            dout1_q      <= dout1_d;
            dout2_q      <= dout2_d;
            dout3_q      <= dout3_d;
        end
    end

    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;
    assign dout1      = dout1_q;
    assign dout2      = dout2_q;
    assign dout3      = dout3_q;

endmodule

`default_nettype wire
